// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and owner ids.
// Core-side requesters and benches import these to decode arbiter behaviour.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the controller's single CPU port between IFU fetches and LSU loads/stores.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, done pulse to the owner only.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter logic [2:0]  IFU_BYTES   = 3'b010,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ifu_req,
    input  logic [63:0] i_ifu_addr,
    output logic        o_ifu_done,
    output logic [63:0] o_ifu_rdata,
    input  logic        i_lsu_req,
    input  logic        i_lsu_we,
    input  logic [63:0] i_lsu_addr,
    input  logic [2:0]  i_lsu_bytes,
    input  logic [63:0] i_lsu_wdata,
    output logic        o_lsu_done,
    output logic [63:0] o_lsu_rdata,
    output logic        o_mem_r_ena,
    output logic        o_mem_w_ena,
    output logic [63:0] o_mem_addr,
    output logic [2:0]  o_mem_bytes,
    output logic [63:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic [63:0] i_mem_rdata,
    output logic        o_timeout_err
);

    arb_state_t  r_state;
    logic        r_owner;
    logic        r_last_gnt;
    logic        r_mem_r_ena;
    logic        r_mem_w_ena;
    logic [63:0] r_mem_addr;
    logic [2:0]  r_mem_bytes;
    logic [63:0] r_mem_wdata;
    logic        r_ifu_done;
    logic        r_lsu_done;
    logic [63:0] r_ifu_rdata;
    logic [63:0] r_lsu_rdata;
    logic [15:0] r_wd_cnt;
    logic        r_timeout_err;

    logic        w_any_req;
    logic        w_gnt_lsu;
    logic [31:0] w_wd_next;

    // On a tie the round-robin pick goes to whoever was not granted last.
    always_comb begin
        w_any_req = i_ifu_req | i_lsu_req;
        if (i_ifu_req && i_lsu_req)
            w_gnt_lsu = ROUND_ROBIN ? (r_last_gnt == OWN_IFU) : 1'b1;
        else
            w_gnt_lsu = i_lsu_req;
    end

    assign w_wd_next = 32'(r_wd_cnt) + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_IFU;
            r_last_gnt    <= OWN_IFU;
            r_mem_r_ena   <= 1'b0;
            r_mem_w_ena   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_bytes   <= '0;
            r_mem_wdata   <= '0;
            r_ifu_done    <= 1'b0;
            r_lsu_done    <= 1'b0;
            r_ifu_rdata   <= '0;
            r_lsu_rdata   <= '0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_mem_r_ena <= 1'b0;
            r_mem_w_ena <= 1'b0;
            r_ifu_done  <= 1'b0;
            r_lsu_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner    <= w_gnt_lsu;
                        r_last_gnt <= w_gnt_lsu;
                        if (w_gnt_lsu) begin
                            r_mem_addr  <= i_lsu_addr;
                            r_mem_bytes <= i_lsu_bytes;
                            r_mem_wdata <= i_lsu_wdata;
                            r_mem_r_ena <= ~i_lsu_we;
                            r_mem_w_ena <= i_lsu_we;
                        end else begin
                            r_mem_addr  <= i_ifu_addr;
                            r_mem_bytes <= IFU_BYTES;
                            r_mem_wdata <= '0;
                            r_mem_r_ena <= 1'b1;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_wd_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wd_cnt != 16'hFFFF)
                        r_wd_cnt <= r_wd_cnt + 16'd1;
                    // Flag only; the transaction still waits for the controller.
                    if (TIMEOUT != 0 && w_wd_next >= TIMEOUT)
                        r_timeout_err <= 1'b1;
                    if (i_mem_ready) begin
                        if (r_owner == OWN_LSU) begin
                            r_lsu_rdata <= i_mem_rdata;
                            r_lsu_done  <= 1'b1;
                        end else begin
                            r_ifu_rdata <= i_mem_rdata;
                            r_ifu_done  <= 1'b1;
                        end
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ifu_done    = r_ifu_done;
    assign o_ifu_rdata   = r_ifu_rdata;
    assign o_lsu_done    = r_lsu_done;
    assign o_lsu_rdata   = r_lsu_rdata;
    assign o_mem_r_ena   = r_mem_r_ena;
    assign o_mem_w_ena   = r_mem_w_ena;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_bytes   = r_mem_bytes;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT A is round-robin with TIMEOUT=8, DUT B is fixed-priority.
// A small responder per DUT answers each enable pulse with a one-cycle mem_ready.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_ifu_req, a_ifu_done, a_lsu_req, a_lsu_we, a_lsu_done;
    logic [63:0] a_ifu_addr, a_ifu_rdata, a_lsu_addr, a_lsu_wdata, a_lsu_rdata;
    logic [2:0]  a_lsu_bytes, a_mem_bytes;
    logic        a_mem_r_ena, a_mem_w_ena, a_mem_ready, a_tmo;
    logic [63:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

    logic        b_ifu_req, b_ifu_done, b_lsu_req, b_lsu_we, b_lsu_done;
    logic [63:0] b_ifu_addr, b_ifu_rdata, b_lsu_addr, b_lsu_wdata, b_lsu_rdata;
    logic [2:0]  b_lsu_bytes, b_mem_bytes;
    logic        b_mem_r_ena, b_mem_w_ena, b_mem_ready, b_tmo;
    logic [63:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_tot = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ROUND_ROBIN(1'b1), .IFU_BYTES(3'b010), .TIMEOUT(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_ifu_req(a_ifu_req), .i_ifu_addr(a_ifu_addr),
        .o_ifu_done(a_ifu_done), .o_ifu_rdata(a_ifu_rdata),
        .i_lsu_req(a_lsu_req), .i_lsu_we(a_lsu_we), .i_lsu_addr(a_lsu_addr),
        .i_lsu_bytes(a_lsu_bytes), .i_lsu_wdata(a_lsu_wdata),
        .o_lsu_done(a_lsu_done), .o_lsu_rdata(a_lsu_rdata),
        .o_mem_r_ena(a_mem_r_ena), .o_mem_w_ena(a_mem_w_ena),
        .o_mem_addr(a_mem_addr), .o_mem_bytes(a_mem_bytes), .o_mem_wdata(a_mem_wdata),
        .i_mem_ready(a_mem_ready), .i_mem_rdata(a_mem_rdata),
        .o_timeout_err(a_tmo)
    );

    mem_port_arbiter #(.ROUND_ROBIN(1'b0), .IFU_BYTES(3'b010), .TIMEOUT(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_ifu_req(b_ifu_req), .i_ifu_addr(b_ifu_addr),
        .o_ifu_done(b_ifu_done), .o_ifu_rdata(b_ifu_rdata),
        .i_lsu_req(b_lsu_req), .i_lsu_we(b_lsu_we), .i_lsu_addr(b_lsu_addr),
        .i_lsu_bytes(b_lsu_bytes), .i_lsu_wdata(b_lsu_wdata),
        .o_lsu_done(b_lsu_done), .o_lsu_rdata(b_lsu_rdata),
        .o_mem_r_ena(b_mem_r_ena), .o_mem_w_ena(b_mem_w_ena),
        .o_mem_addr(b_mem_addr), .o_mem_bytes(b_mem_bytes), .o_mem_wdata(b_mem_wdata),
        .i_mem_ready(b_mem_ready), .i_mem_rdata(b_mem_rdata),
        .o_timeout_err(b_tmo)
    );

    // Controller models: pending after an enable, ready one cycle later unless held.
    logic a_pend, b_pend;
    bit   a_hold = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_pend <= 1'b0;
            a_mem_ready <= 1'b0;
        end else begin
            a_mem_ready <= 1'b0;
            if (a_mem_r_ena || a_mem_w_ena) a_pend <= 1'b1;
            else if (a_pend && !a_hold) begin
                a_mem_ready <= 1'b1;
                a_pend <= 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_pend <= 1'b0;
            b_mem_ready <= 1'b0;
        end else begin
            b_mem_ready <= 1'b0;
            if (b_mem_r_ena || b_mem_w_ena) b_pend <= 1'b1;
            else if (b_pend) begin
                b_mem_ready <= 1'b1;
                b_pend <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a done pulse at a negedge; reports cycles waited and owner.
    task automatic wait_done(input bit use_b, output int cyc, output logic is_lsu);
        logic di, dl;
        cyc = 0;
        is_lsu = 1'bx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            cyc++;
            di = use_b ? b_ifu_done : a_ifu_done;
            dl = use_b ? b_lsu_done : a_lsu_done;
            if (di || dl) begin
                chk("one_done", {63'd0, di & dl}, 64'd0);
                is_lsu = dl;
                return;
            end
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    // Bounded wait for an enable pulse on DUT A; returns negedges waited.
    task automatic wait_a_ena(output int cyc);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (a_mem_r_ena || a_mem_w_ena) return;
        end
        chk("ena_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int   c, c2;
        logic l;
        bit   seen;
        {a_ifu_req, a_lsu_req, a_lsu_we, b_ifu_req, b_lsu_req, b_lsu_we} = '0;
        {a_ifu_addr, a_lsu_addr, a_lsu_wdata, b_ifu_addr, b_lsu_addr, b_lsu_wdata} = '0;
        a_lsu_bytes = 3'b000;
        b_lsu_bytes = 3'b000;
        a_mem_rdata = '0;
        b_mem_rdata = 64'h0000_0000_1111_2222;

        repeat (2) @(negedge clk);
        chk("rst_ifu_done", {63'd0, a_ifu_done}, 64'd0);
        chk("rst_r_ena",    {63'd0, a_mem_r_ena | a_mem_w_ena}, 64'd0);
        chk("rst_addr",     a_mem_addr, 64'd0);
        chk("rst_tmo",      {63'd0, a_tmo}, 64'd0);
        chk("rst_rdata",    a_lsu_rdata | a_ifu_rdata, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // IFU-only fetch
        a_mem_rdata = 64'h0000_0000_DEAD_BEEF;
        a_ifu_addr  = 64'h1000;
        a_ifu_req   = 1'b1;
        wait_a_ena(c);
        chk("ifu_iss_lat", c, 1);
        chk("ifu_w_ena",   {63'd0, a_mem_w_ena}, 64'd0);
        chk("ifu_bytes",   {61'd0, a_mem_bytes}, 64'd2);
        chk("ifu_addr",    a_mem_addr, 64'h1000);
        wait_done(1'b0, c2, l);
        chk("ifu_owner",   {63'd0, l}, 64'd0);
        chk("ifu_rdata",   a_ifu_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("ifu_lat",     c + c2, 4);
        a_ifu_req = 1'b0;
        @(negedge clk);
        chk("ifu_done_pulse", {62'd0, a_ifu_done, a_lsu_done}, 64'd0);

        // LSU store
        a_lsu_we    = 1'b1;
        a_lsu_addr  = 64'h2008;
        a_lsu_bytes = 3'b011;
        a_lsu_wdata = 64'h0123_4567_89AB_CDEF;
        a_lsu_req   = 1'b1;
        wait_a_ena(c);
        chk("st_w_ena",  {63'd0, a_mem_w_ena}, 64'd1);
        chk("st_r_ena",  {63'd0, a_mem_r_ena}, 64'd0);
        chk("st_wdata",  a_mem_wdata, 64'h0123_4567_89AB_CDEF);
        chk("st_bytes",  {61'd0, a_mem_bytes}, 64'd3);
        chk("st_addr",   a_mem_addr, 64'h2008);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = a_mem_ready;
        end
        chk("st_ready_seen", {63'd0, seen}, 64'd1);
        @(negedge clk);
        chk("st_done", {62'd0, a_lsu_done, a_ifu_done}, 64'd2);
        a_lsu_req = 1'b0;
        a_lsu_we  = 1'b0;
        @(negedge clk);

        // Round-robin tie from reset: LSU, IFU, LSU, IFU
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        a_ifu_addr = 64'h3000;
        a_lsu_addr = 64'h4000;
        a_ifu_req  = 1'b1;
        a_lsu_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, c, l);
            chk($sformatf("rr_gnt%0d", k), {63'd0, l}, (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        a_ifu_req = 1'b0;
        a_lsu_req = 1'b0;
        @(negedge clk);

        // Fixed priority: IFU starved while LSU holds its request
        b_ifu_addr = 64'h3000;
        b_lsu_addr = 64'h4000;
        b_ifu_req  = 1'b1;
        b_lsu_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b1, c, l);
            chk($sformatf("fp_gnt%0d", k), {63'd0, l}, 64'd1);
        end
        chk("fp_rdata", b_lsu_rdata, 64'h0000_0000_1111_2222);
        b_ifu_req = 1'b0;
        b_lsu_req = 1'b0;
        @(negedge clk);

        // Watchdog: flag after the 8th WAIT cycle, late ready still completes
        chk("wd_pre", {63'd0, a_tmo}, 64'd0);
        a_hold      = 1'b1;
        a_mem_rdata = 64'h0000_0000_CAFE_F00D;
        a_ifu_addr  = 64'h5000;
        a_ifu_req   = 1'b1;
        wait_a_ena(c);
        repeat (8) @(posedge clk);
        #1 chk("wd_7cyc", {63'd0, a_tmo}, 64'd0);
        @(posedge clk);
        #1 chk("wd_8cyc", {63'd0, a_tmo}, 64'd1);
        repeat (11) @(negedge clk);
        a_hold = 1'b0;
        wait_done(1'b0, c, l);
        chk("wd_owner", {63'd0, l}, 64'd0);
        chk("wd_rdata", a_ifu_rdata, 64'h0000_0000_CAFE_F00D);
        chk("wd_sticky", {63'd0, a_tmo}, 64'd1);
        a_ifu_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT clears everything, then a clean fetch
        a_hold     = 1'b1;
        a_ifu_addr = 64'h6000;
        a_ifu_req  = 1'b1;
        wait_a_ena(c);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmid_tmo",   {63'd0, a_tmo}, 64'd0);
        chk("rmid_addr",  a_mem_addr, 64'd0);
        chk("rmid_bytes", {61'd0, a_mem_bytes}, 64'd0);
        chk("rmid_rdata", a_ifu_rdata, 64'd0);
        chk("rmid_ctl",   {60'd0, a_ifu_done, a_lsu_done, a_mem_r_ena, a_mem_w_ena}, 64'd0);
        a_ifu_req = 1'b0;
        a_hold    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        a_mem_rdata = 64'h0000_0000_0000_55AA;
        a_ifu_addr  = 64'h7000;
        a_ifu_req   = 1'b1;
        wait_done(1'b0, c, l);
        chk("post_owner", {63'd0, l}, 64'd0);
        chk("post_rdata", a_ifu_rdata, 64'h0000_0000_0000_55AA);
        chk("post_addr",  a_mem_addr, 64'h7000);
        a_ifu_req = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
